streaming_accumulator: RTL and testbench

//   Running-sum accumulator for a fixed-point sample stream. It adds one unsigned
//   16-bit sample into a 32-bit accumulator on every clock edge.

---
 rtl/fxp_pkg.sv | 11 +
 rtl/acc_adder.sv | 20 ++
 rtl/streaming_accumulator.sv | 42 ++++
 tb/tb_streaming_accumulator.sv | 118 +++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point widths and types for the arithmetic unit.
// Sample and accumulator widths are fixed here so blocks agree on them.
package fxp_pkg;

    localparam int FXP_DATA_W = 16;
    localparam int FXP_ACC_W  = 32;

    typedef logic [FXP_DATA_W-1:0] fxp_sample_t;
    typedef logic [FXP_ACC_W-1:0]  fxp_acc_t;

endpackage

// File: rtl/acc_adder.sv
// Combinational modulo-2^ACC_W adder of an unsigned narrow operand
// into a wide accumulator operand; reusable by other fixed-point blocks.
module acc_adder
    import fxp_pkg::*;
#(
    parameter int DATA_W = FXP_DATA_W,
    parameter int ACC_W  = FXP_ACC_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [ACC_W-1:0]  sum_o
);

    logic [ACC_W-1:0] sample_ext;

    // Unsigned operand: zero-extend, never sign-extend; carry-out is dropped.
    assign sample_ext = ACC_W'(sample_i);
    assign sum_o      = acc_i + sample_ext;

endmodule

// File: rtl/streaming_accumulator.sv
// Running-sum accumulator: one unsigned sample is added every clock,
// with a synchronous active-high clear and a registered output.
module streaming_accumulator
    import fxp_pkg::*;
#(
    parameter int DATA_W = FXP_DATA_W,
    parameter int ACC_W  = FXP_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    output logic [ACC_W-1:0]  sum_out
);

    // Silicon powers up undefined; the initialiser only fixes the sim value.
    logic [ACC_W-1:0] acc_q = '0;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] add_sum;

    acc_adder #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc_i    (acc_q),
        .sample_i (data_in),
        .sum_o    (add_sum)
    );

    always_comb begin
        acc_d = add_sum;
        if (reset) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign sum_out = acc_q;

endmodule

// File: tb/tb_streaming_accumulator.sv
// Self-checking bench: directed scenarios with literal expectations plus
// a per-cycle scoreboard against a sum-since-reset reference model.
module tb_streaming_accumulator;
    import fxp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    fxp_sample_t data_in;
    fxp_acc_t    sum_out;

    int checks   = 0;
    int failures = 0;

    // Reference: plain sum of every sample since the last reset edge.
    longint unsigned mdl_sum = 0;

    streaming_accumulator dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .sum_out (sum_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) mdl_sum <= 0;
        else       mdl_sum <= mdl_sum + longint'(data_in);
    end

    task automatic chk(input string name, input fxp_acc_t act,
                       input fxp_acc_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare on every falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("scoreboard", sum_out, fxp_acc_t'(mdl_sum % 64'h1_0000_0000));
    end

    // Drive inputs right after a falling edge, then wait for the next one.
    task automatic step(input bit r, input fxp_sample_t d);
        reset   = r;
        data_in = d;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        data_in = '0;
        #1;
        chk("powerup", sum_out, 32'h0);
        @(negedge clk);

        // 1: reset held two cycles, then 1..16
        step(1'b1, 16'd0);
        step(1'b1, 16'd0);
        chk("reset_held", sum_out, 32'h0);
        for (int i = 1; i <= 16; i++) step(1'b0, fxp_sample_t'(i));
        chk("sum_1_to_16", sum_out, 32'h0000_0088);

        // 2: zero samples hold the sum
        for (int i = 0; i < 5; i++) step(1'b0, 16'd0);
        chk("hold_zero", sum_out, 32'd136);

        // 3: full-scale run to all-ones, then wrap
        step(1'b1, 16'hFFFF);
        chk("reset_ignores_data", sum_out, 32'h0);
        for (int i = 0; i < 65537; i++) step(1'b0, 16'hFFFF);
        chk("all_ones", sum_out, 32'hFFFF_FFFF);
        step(1'b0, 16'd1);
        chk("wrap", sum_out, 32'h0000_0000);

        // 4: unsigned MSB
        step(1'b1, 16'd0);
        step(1'b0, 16'h8000);
        chk("msb_once", sum_out, 32'h0000_8000);
        step(1'b0, 16'h8000);
        chk("msb_twice", sum_out, 32'h0001_0000);

        // 5: reset mid-stream discards the sum and the sample on that edge
        step(1'b1, 16'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd100);
        chk("sum_300", sum_out, 32'd300);
        step(1'b1, 16'd7);
        chk("mid_reset", sum_out, 32'd0);
        step(1'b0, 16'd5);
        chk("fresh_after_reset", sum_out, 32'd5);

        // Multi-cycle reset keeps zero
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'd9);
            chk("reset_multi", sum_out, 32'd0);
        end

        // Only the value present at the rising edge counts
        reset   = 1'b0;
        data_in = 16'd50;
        #2 data_in = 16'd20;
        @(negedge clk);
        chk("edge_value_only", sum_out, 32'd20);

        // 6: random samples with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0),
                 fxp_sample_t'($urandom_range(0, 16'hFFFF)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
